fifo_ptr_flags: RTL and testbench

- Parametrised pointer-and-status unit for the synchronous FIFO.
- Owns the binary and Gray write/read pointers and generates registered full/empty flags from Gray-pointer comparison.
- Adds almost-full/almost-empty thresholds, an occupancy count and a synchronous clear.
- Drives RAM addresses to the storage array; the Gray pointers are exported for a future dual-clock variant.

---
 rtl/fifo_ptr_flags.sv | 113 +++++++++++
 tb/tb_fifo_ptr_flags.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_flags.sv
// Pointer and status unit for the synchronous FIFO: binary/Gray pointers, registered flags, level.
// Define FIFO_PTR_ERR_EN to add sticky overflow/underflow outputs.
module fifo_ptr_flags #(
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned AF_LEVEL = 6,
   parameter int unsigned AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic [ADDR_W-1:0] w_addr,
   output logic [ADDR_W-1:0] r_addr,
   output logic              wr_accept,
   output logic              rd_accept,
   output logic [ADDR_W:0]   w_ptr_gray,
   output logic [ADDR_W:0]   r_ptr_gray,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
`ifdef FIFO_PTR_ERR_EN
   output logic              overflow,
   output logic              underflow,
`endif
   output logic [ADDR_W:0]   level
);

   localparam int unsigned PW = ADDR_W + 1;

   logic [PW-1:0] w_bin_q, w_bin_d, r_bin_q, r_bin_d;
   logic [PW-1:0] w_gray_q, w_gray_d, r_gray_q, r_gray_d;
   logic [PW-1:0] level_q, level_d;
   logic          full_q, full_d, empty_q, empty_d;
   logic          af_q, af_d, ae_q, ae_d;

   always_comb begin
      wr_accept = wr_en && !full_q;
      rd_accept = rd_en && !empty_q;

      w_bin_d  = w_bin_q + PW'(wr_accept);
      r_bin_d  = r_bin_q + PW'(rd_accept);
      w_gray_d = w_bin_d ^ (w_bin_d >> 1);
      r_gray_d = r_bin_d ^ (r_bin_d >> 1);

      // Full: Gray pointers one lap apart differ only in their top two bits.
      empty_d = (w_gray_d == r_gray_d);
      full_d  = (w_gray_d[PW-1:PW-2] == ~r_gray_d[PW-1:PW-2]) &&
                (w_gray_d[PW-3:0] == r_gray_d[PW-3:0]);

      level_d = w_bin_d - r_bin_d;
      af_d    = (level_d >= PW'(AF_LEVEL));
      ae_d    = (level_d <= PW'(AE_LEVEL));
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         w_bin_q  <= '0;
         r_bin_q  <= '0;
         w_gray_q <= '0;
         r_gray_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
      end else begin
         w_bin_q  <= w_bin_d;
         r_bin_q  <= r_bin_d;
         w_gray_q <= w_gray_d;
         r_gray_q <= r_gray_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
      end
   end

`ifdef FIFO_PTR_ERR_EN
   logic ovf_q, ovf_d, unf_q, unf_d;

   always_comb begin
      ovf_d = ovf_q | (wr_en & full_q);
      unf_d = unf_q | (rd_en & empty_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`endif

   assign w_addr       = w_bin_q[ADDR_W-1:0];
   assign r_addr       = r_bin_q[ADDR_W-1:0];
   assign w_ptr_gray   = w_gray_q;
   assign r_ptr_gray   = r_gray_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign level        = level_q;

endmodule

// File: tb/tb_fifo_ptr_flags.sv
// Self-checking bench for fifo_ptr_flags: directed scenarios plus randomized traffic against
// an occupancy-count reference model.
module tb_fifo_ptr_flags;

   localparam int ADDR_W   = 3;
   localparam int AF_LEVEL = 6;
   localparam int AE_LEVEL = 2;
   localparam int DEPTH    = 1 << ADDR_W;
   localparam int PW       = ADDR_W + 1;
   localparam int MOD      = 1 << PW;

   logic              clk, rst_n, clr, wr_en, rd_en;
   logic [ADDR_W-1:0] w_addr, r_addr;
   logic              wr_accept, rd_accept;
   logic [PW-1:0]     w_ptr_gray, r_ptr_gray, level;
   logic              full, empty, almost_full, almost_empty;
`ifdef FIFO_PTR_ERR_EN
   logic              overflow, underflow;
`endif

   fifo_ptr_flags #(
      .ADDR_W  (ADDR_W),
      .AF_LEVEL(AF_LEVEL),
      .AE_LEVEL(AE_LEVEL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .w_addr      (w_addr),
      .r_addr      (r_addr),
      .wr_accept   (wr_accept),
      .rd_accept   (rd_accept),
      .w_ptr_gray  (w_ptr_gray),
      .r_ptr_gray  (r_ptr_gray),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
`ifdef FIFO_PTR_ERR_EN
      .overflow    (overflow),
      .underflow   (underflow),
`endif
      .level       (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  n_run, n_fail;
   // Model: total accepted writes/reads since last reset/clear.
   int  m_wr, m_rd;
   bit  m_ovf, m_unf;
   bit  exp_wacc, exp_racc;
   logic got_wacc, got_racc;

   function automatic logic [PW-1:0] gray_of(input int cnt);
      int b;
      b = cnt % MOD;
      return PW'(b ^ (b >> 1));
   endfunction

   function automatic int m_lvl();
      return m_wr - m_rd;
   endfunction

   // One clock: drive, capture combinational accepts, clock edge, advance the model.
   task automatic cycle(input bit w, input bit r, input bit c, input bit rn);
      int lvl;
      wr_en = w; rd_en = r; clr = c; rst_n = rn;
      lvl = m_lvl();
      exp_wacc = w && (lvl != DEPTH);
      exp_racc = r && (lvl != 0);
      #1;
      got_wacc = wr_accept;
      got_racc = rd_accept;
      @(posedge clk);
      if (!rn || c) begin
         m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
      end else begin
         if (w && lvl == DEPTH) m_ovf = 1;
         if (r && lvl == 0) m_unf = 1;
         if (exp_wacc) m_wr++;
         if (exp_racc) m_rd++;
      end
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n_run++; if (level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
      n_run++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
      n_run++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
      n_run++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b want 1", almost_empty); end
      n_run++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b want 0", almost_full); end
      n_run++; if (w_ptr_gray !== '0 || r_ptr_gray !== '0 || w_addr !== '0 || r_addr !== '0) begin
         n_fail++; $display("FAIL reset_ptrs got wg=%h rg=%h wa=%0d ra=%0d want all 0",
                            w_ptr_gray, r_ptr_gray, w_addr, r_addr);
      end
   endtask

   task automatic test_fill();
      logic [PW-1:0] want_gray;
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b1);
         n_run++; if (got_wacc !== 1'b1) begin n_fail++; $display("FAIL fill_accept[%0d] got %b want 1", i, got_wacc); end
         n_run++; if (level !== PW'(i)) begin n_fail++; $display("FAIL fill_level[%0d] got %0d want %0d", i, level, i); end
         n_run++; if (almost_full !== (i >= AF_LEVEL)) begin
            n_fail++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, i >= AF_LEVEL);
         end
         n_run++; if (full !== (i == DEPTH)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, full, i == DEPTH); end
         n_run++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d] got %b want 0", i, empty); end
      end
      want_gray = 4'b1100;
      n_run++; if (w_ptr_gray !== want_gray) begin n_fail++; $display("FAIL fill_wgray got %b want %b", w_ptr_gray, want_gray); end
   endtask

   task automatic test_overflow();
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      n_run++; if (got_wacc !== 1'b0) begin n_fail++; $display("FAIL ovf_accept got %b want 0", got_wacc); end
      n_run++; if (level !== PW'(DEPTH)) begin n_fail++; $display("FAIL ovf_level got %0d want %0d", level, DEPTH); end
      n_run++; if (w_addr !== '0 || w_ptr_gray !== gray_of(DEPTH)) begin
         n_fail++; $display("FAIL ovf_wptr got wa=%0d wg=%b want 0/%b", w_addr, w_ptr_gray, gray_of(DEPTH));
      end
      n_run++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", full); end
`ifdef FIFO_PTR_ERR_EN
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      n_run++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      n_run++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_unf got %b want 0", underflow); end
`endif
   endtask

   task automatic test_full_rw();
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      n_run++; if (got_wacc !== 1'b0 || got_racc !== 1'b1) begin
         n_fail++; $display("FAIL fullrw_accept got w=%b r=%b want w=0 r=1", got_wacc, got_racc);
      end
      n_run++; if (level !== PW'(DEPTH - 1)) begin n_fail++; $display("FAIL fullrw_level got %0d want %0d", level, DEPTH - 1); end
      n_run++; if (full !== 1'b0) begin n_fail++; $display("FAIL fullrw_full got %b want 0", full); end
      n_run++; if (r_addr !== ADDR_W'(1)) begin n_fail++; $display("FAIL fullrw_raddr got %0d want 1", r_addr); end
   endtask

   task automatic test_empty_rw();
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      n_run++; if (got_wacc !== 1'b1 || got_racc !== 1'b0) begin
         n_fail++; $display("FAIL emptyrw_accept got w=%b r=%b want w=1 r=0", got_wacc, got_racc);
      end
      n_run++; if (level !== PW'(1)) begin n_fail++; $display("FAIL emptyrw_level got %0d want 1", level); end
      n_run++; if (empty !== 1'b0) begin n_fail++; $display("FAIL emptyrw_empty got %b want 0", empty); end
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      n_run++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin
         n_fail++; $display("FAIL emptyrw_drain got e=%b ae=%b want 1/1", empty, almost_empty);
      end
`ifdef FIFO_PTR_ERR_EN
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      n_run++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL emptyrw_unf got %b want 1", underflow); end
`endif
   endtask

   task automatic test_wrap();
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 1'b1);
         n_run++; if (level !== PW'(3) || full !== 1'b0 || empty !== 1'b0 || almost_empty !== 1'b0) begin
            n_fail++; $display("FAIL wrap_state[%0d] got lvl=%0d f=%b e=%b ae=%b want 3/0/0/0",
                               i, level, full, empty, almost_empty);
         end
      end
      n_run++; if (w_addr !== ADDR_W'(23 % DEPTH) || w_ptr_gray !== gray_of(23)) begin
         n_fail++; $display("FAIL wrap_wptr got wa=%0d wg=%b want %0d/%b", w_addr, w_ptr_gray, 23 % DEPTH, gray_of(23));
      end
      n_run++; if (r_addr !== ADDR_W'(20 % DEPTH) || r_ptr_gray !== gray_of(20)) begin
         n_fail++; $display("FAIL wrap_rptr got ra=%0d rg=%b want %0d/%b", r_addr, r_ptr_gray, 20 % DEPTH, gray_of(20));
      end
   endtask

   // mode 0: clr with rst_n high; mode 1: rst_n low. Both with wr_en asserted.
   task automatic test_clear();
      for (int mode = 0; mode < 2; mode++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
         n_run++; if (level !== PW'(5)) begin n_fail++; $display("FAIL clear_pre[%0d] got %0d want 5", mode, level); end
         cycle(1'b1, 1'b0, mode == 0, mode == 0);
         n_run++; if (level !== '0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1) begin
            n_fail++; $display("FAIL clear_flags[%0d] got lvl=%0d e=%b f=%b ae=%b want 0/1/0/1",
                               mode, level, empty, full, almost_empty);
         end
         n_run++; if (w_addr !== '0 || r_addr !== '0 || w_ptr_gray !== '0 || r_ptr_gray !== '0) begin
            n_fail++; $display("FAIL clear_ptrs[%0d] got wa=%0d ra=%0d wg=%b rg=%b want 0", mode, w_addr, r_addr,
                               w_ptr_gray, r_ptr_gray);
         end
`ifdef FIFO_PTR_ERR_EN
         n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_ovf[%0d] got %b want 0", mode, overflow); end
`endif
      end
   endtask

   task automatic test_random();
      bit w, r, c;
      int lvl;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 600; i++) begin
         // Drift toward full, then toward empty, so both boundaries get exercised.
         w = ((i / 100) % 2 == 0) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
         r = ((i / 100) % 2 == 0) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
         c = ($urandom_range(63, 0) == 0);
         cycle(w, r, c, 1'b1);
         lvl = m_lvl();
         n_run++; if (got_wacc !== exp_wacc || got_racc !== exp_racc) begin
            n_fail++; $display("FAIL rnd_accept[%0d] got w=%b r=%b want w=%b r=%b", i, got_wacc, got_racc, exp_wacc, exp_racc);
         end
         n_run++; if (level !== PW'(lvl)) begin n_fail++; $display("FAIL rnd_level[%0d] got %0d want %0d", i, level, lvl); end
         n_run++; if (full !== (lvl == DEPTH) || empty !== (lvl == 0)) begin
            n_fail++; $display("FAIL rnd_fe[%0d] got f=%b e=%b want f=%b e=%b", i, full, empty, lvl == DEPTH, lvl == 0);
         end
         n_run++; if (almost_full !== (lvl >= AF_LEVEL) || almost_empty !== (lvl <= AE_LEVEL)) begin
            n_fail++; $display("FAIL rnd_almost[%0d] got af=%b ae=%b want af=%b ae=%b", i, almost_full, almost_empty,
                               lvl >= AF_LEVEL, lvl <= AE_LEVEL);
         end
         n_run++; if (w_addr !== ADDR_W'(m_wr % DEPTH) || r_addr !== ADDR_W'(m_rd % DEPTH)) begin
            n_fail++; $display("FAIL rnd_addr[%0d] got wa=%0d ra=%0d want %0d/%0d", i, w_addr, r_addr, m_wr % DEPTH, m_rd % DEPTH);
         end
         n_run++; if (w_ptr_gray !== gray_of(m_wr) || r_ptr_gray !== gray_of(m_rd)) begin
            n_fail++; $display("FAIL rnd_gray[%0d] got wg=%b rg=%b want %b/%b", i, w_ptr_gray, r_ptr_gray,
                               gray_of(m_wr), gray_of(m_rd));
         end
`ifdef FIFO_PTR_ERR_EN
         n_run++; if (overflow !== m_ovf || underflow !== m_unf) begin
            n_fail++; $display("FAIL rnd_err[%0d] got o=%b u=%b want o=%b u=%b", i, overflow, underflow, m_ovf, m_unf);
         end
`endif
      end
   endtask

   initial begin
      n_run = 0; n_fail = 0;
      m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
      rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      test_reset();
      test_fill();
      test_overflow();
      test_full_rw();
      test_empty_rw();
      test_wrap();
      test_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
